pipeline_fetch: RTL and testbench

PIPELINE_FETCH -- requirements
Module: pipeline_fetch

---
 rtl/pipeline_pkg.sv | 24 ++
 rtl/fetch_buffer.sv | 62 ++++++
 rtl/pipeline_fetch.sv | 126 ++++++++++++
 tb/tb_pipeline_fetch.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_pkg
// Brief    : Shared constants and types for the instruction fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    localparam logic [31:0] c_nop_instr = 32'h0000_0013;
    localparam logic [31:0] c_reset_pc  = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer
// Brief    : Two-entry FIFO of {pc, instr} between fetch and decode.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import pipeline_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic [1:0]   count_o
);

    fetch_entry_t r_mem [2];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_count;
    logic         w_do_push;
    logic         w_do_pop;

    // A full buffer only accepts a push when the head leaves in the same cycle
    assign w_do_pop  = pop_i & (r_count != 2'd0);
    assign w_do_push = push_i & ((r_count != 2'd2) | w_do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (clear_i) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data_i;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_o  = r_mem[r_rd_ptr];
    assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_fetch.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_fetch
// Brief    : Instruction fetch stage with one outstanding request and redirect.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_fetch
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instruction_o,
    output logic [31:0] pcsrc_o,
    output logic        valid_o
);

    localparam logic [31:0] c_align_mask = 32'hFFFF_FFFC;

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  r_granted_pc;
    logic         r_req;

    logic         w_grant;
    logic         w_push;
    logic         w_pop;
    logic         w_valid;
    logic [1:0]   w_count;
    logic [1:0]   w_count_next;
    fetch_entry_t w_head;
    fetch_entry_t w_push_data;

    assign w_grant     = r_req & imem_gnt_i;
    assign w_valid     = (w_count != 2'd0);
    assign w_push      = (r_state == S_WAIT) & imem_rvalid_i & ~redirect_i;
    assign w_pop       = w_valid & ~stall_i & ~redirect_i;
    assign w_push_data = {r_granted_pc, imem_rdata_i};

    fetch_buffer u_fetch_buffer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (redirect_i),
        .push_i      (w_push),
        .push_data_i (w_push_data),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .count_o     (w_count)
    );

    // Occupancy after this edge, so the request line can be registered
    always_comb begin
        w_count_next = w_count;
        if (redirect_i) begin
            w_count_next = 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_next = w_count + 2'd1;
                2'b01:   w_count_next = w_count - 2'd1;
                default: w_count_next = w_count;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_REQ: begin
                if (w_grant) begin
                    w_state_next = redirect_i ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    w_state_next = S_REQ;
                end else if (redirect_i) begin
                    w_state_next = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rvalid_i) begin
                    w_state_next = S_REQ;
                end
            end
            default: w_state_next = S_REQ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_REQ;
            r_fetch_pc   <= RESET_PC & c_align_mask;
            r_granted_pc <= '0;
            r_req        <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_req   <= (w_state_next == S_REQ) && (w_count_next != 2'd2);
            if (redirect_i) begin
                r_fetch_pc <= redirect_pc_i & c_align_mask;
            end else if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_grant) begin
                r_granted_pc <= r_fetch_pc;
            end
        end
    end

    assign imem_req_o    = r_req;
    assign imem_addr_o   = r_fetch_pc;
    assign valid_o       = w_valid;
    assign instruction_o = w_valid ? w_head.instr : c_nop_instr;
    assign pcsrc_o       = w_valid ? w_head.pc : 32'h0000_0000;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_fetch
// Brief    : Directed and random stimulus against a queue-based fetch model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_fetch;
    import pipeline_pkg::*;

    logic        clk_i;
    logic        rst_ni;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        stall_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instruction_o;
    logic [31:0] pcsrc_o;
    logic        valid_o;

    pipeline_fetch #(.RESET_PC(c_reset_pc)) u_dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .stall_i       (stall_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instruction_o (instruction_o),
        .pcsrc_o       (pcsrc_o),
        .valid_o       (valid_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    int checks = 0;
    int errors = 0;

    // Model: instructions decode should see, in order, plus the fetch cursor
    exp_t        m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_opc;
    bit          m_out;
    bit          m_drop;
    bit          m_started;

    // Memory responder
    bit          mem_pend;
    int          mem_dly;
    logic [31:0] mem_addr;
    int          lat_mode;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc      = c_reset_pc & 32'hFFFF_FFFC;
        m_opc     = '0;
        m_out     = 1'b0;
        m_drop    = 1'b0;
        m_started = 1'b0;
    endtask

    // Called just after a falling edge: check, drive, advance model, wait a cycle
    task automatic cycle(input bit redir, input logic [31:0] rpc, input bit stall, input bit gnt);
        bit          exp_valid;
        bit          exp_req;
        bit          rv;
        bit          grant;
        bit          resp;
        logic [31:0] rd;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;

        exp_valid = (m_q.size() > 0);
        exp_req   = m_started && !m_out && (m_q.size() < 2);
        exp_instr = c_nop_instr;
        exp_pc    = 32'h0;
        if (exp_valid) begin
            exp_instr = m_q[0].instr;
            exp_pc    = m_q[0].pc;
        end
        check("valid", {31'b0, valid_o}, {31'b0, exp_valid});
        check("instr", instruction_o, exp_instr);
        check("pcsrc", pcsrc_o, exp_pc);
        check("req", {31'b0, imem_req_o}, {31'b0, exp_req});
        if (exp_req) check("addr", imem_addr_o, m_pc);

        rv = 1'b0;
        rd = $urandom;
        if (mem_pend) begin
            if (mem_dly == 0) begin
                rv       = 1'b1;
                rd       = (mem_addr == 32'h0) ? 32'h0010_0093 : $urandom;
                mem_pend = 1'b0;
            end else begin
                mem_dly--;
            end
        end

        redirect_i    = redir;
        redirect_pc_i = rpc;
        stall_i       = stall;
        imem_gnt_i    = gnt;
        imem_rvalid_i = rv;
        imem_rdata_i  = rd;

        grant = exp_req && gnt;
        resp  = rv && m_out;
        if (grant) begin
            mem_pend = 1'b1;
            mem_addr = m_pc;
            mem_dly  = (lat_mode < 0) ? int'($urandom_range(0, 2)) : lat_mode;
        end

        if (redir) begin
            m_q.delete();
            m_pc = rpc & 32'hFFFF_FFFC;
            if (resp) m_out = 1'b0;
            else if (m_out) m_drop = 1'b1;
            if (grant) begin
                m_out  = 1'b1;
                m_drop = 1'b1;
            end
        end else begin
            if (m_q.size() > 0 && !stall) void'(m_q.pop_front());
            if (resp) begin
                if (!m_drop) m_q.push_back('{pc: m_opc, instr: rd});
                m_out = 1'b0;
            end
            if (grant) begin
                m_out  = 1'b1;
                m_drop = 1'b0;
                m_opc  = m_pc;
                m_pc   = m_pc + 32'd4;
            end
        end
        m_started = 1'b1;
        @(negedge clk_i);
    endtask

    initial begin
        rst_ni        = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        stall_i       = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        mem_pend      = 1'b0;
        mem_dly       = 0;
        mem_addr      = '0;
        lat_mode      = 0;
        model_reset();

        repeat (2) @(negedge clk_i);
        check("rst_req", {31'b0, imem_req_o}, 32'h0);
        check("rst_valid", {31'b0, valid_o}, 32'h0);
        check("rst_instr", instruction_o, c_nop_instr);
        check("rst_pcsrc", pcsrc_o, 32'h0);
        rst_ni = 1'b1;

        // First fetch after reset, then stalled fill and in-order drain
        repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check("first_instr", instruction_o, 32'h0010_0093);
        check("first_pc", pcsrc_o, 32'h0);
        repeat (5) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check("full_noreq", {31'b0, imem_req_o}, 32'h0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("drain_pc4", pcsrc_o, 32'h4);
        repeat (4) cycle(1'b0, 32'h0, 1'b0, 1'b1);

        // Redirect while a response is outstanding
        repeat (4) cycle(1'b0, 32'h0, 1'b0, 1'b0);
        lat_mode = 2;
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b1, 32'h0000_0102, 1'b0, 1'b0);
        for (int i = 0; i < 8 && !imem_req_o; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
        check("redir_addr", imem_addr_o, 32'h0000_0100);
        check("redir_noval", {31'b0, valid_o}, 32'h0);
        lat_mode = 0;
        repeat (4) cycle(1'b0, 32'h0, 1'b0, 1'b1);

        // Redirect with a full, stalled buffer
        repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b1, 32'h0000_0200, 1'b1, 1'b1);
        check("flush_valid", {31'b0, valid_o}, 32'h0);
        repeat (4) cycle(1'b0, 32'h0, 1'b0, 1'b1);

        // Address wrap at the top of memory
        repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check("wrap_req", {31'b0, imem_req_o}, 32'h1);
        check("wrap_addr", imem_addr_o, 32'h0);
        repeat (4) cycle(1'b0, 32'h0, 1'b0, 1'b0);

        // Asynchronous reset with a response still outstanding
        lat_mode = 2;
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        #2 rst_ni = 1'b0;
        #1;
        check("arst_req", {31'b0, imem_req_o}, 32'h0);
        check("arst_valid", {31'b0, valid_o}, 32'h0);
        check("arst_instr", instruction_o, c_nop_instr);
        check("arst_pcsrc", pcsrc_o, 32'h0);
        model_reset();
        mem_dly       = 0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni   = 1'b1;
        lat_mode = 0;
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("arst_stale", {31'b0, valid_o}, 32'h0);
        repeat (4) cycle(1'b0, 32'h0, 1'b0, 1'b1);

        // Random traffic
        lat_mode = -1;
        repeat (3000) begin
            cycle($urandom_range(0, 15) == 0, $urandom,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
